// File: rtl/second_max_change_logger.sv
// second_max_change_logger
// Watches the running second-largest value coming from the upstream tracker,
// logs every change as a {value, sample index} event into a small
// first-word-fall-through FIFO, and lets a consumer drain it over valid/ready.
// A full FIFO never back-pressures the upstream stream: the event is dropped,
// a sticky overflow flag is raised and a saturating drop counter advances.
module second_max_change_logger #(
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 16,
    parameter int DEPTH      = 4,
    parameter int DROP_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     din,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_value,
    output logic [TS_WIDTH-1:0]       out_ts,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [DROP_WIDTH-1:0]     drop_count,
    input  logic                      clear_ovf
);

    // Pointer geometry: low AW bits index storage, the extra MSB is the wrap
    // bit that distinguishes full from empty when the low bits match.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Saturating increment for the dropped-event counter: it sticks at
    // all-ones rather than wrapping back to a misleadingly small value.
    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + DROP_WIDTH'(1);
    endfunction

    // Sample index advance; wraps silently modulo 2^TS_WIDTH.
    function automatic logic [TS_WIDTH-1:0] ts_next(input logic [TS_WIDTH-1:0] v);
        return v + TS_WIDTH'(1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] prev_q,      prev_d;
    logic [TS_WIDTH-1:0]   ts_cnt_q,    ts_cnt_d;
    logic [PW-1:0]         wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q,    rd_ptr_d;
    logic                  overflow_q,  overflow_d;
    logic [DROP_WIDTH-1:0] drop_cnt_q,  drop_cnt_d;

    // Event storage is pure data: it is never reset, validity comes only
    // from the pointers.
    logic [DATA_WIDTH-1:0] val_mem_q [DEPTH];
    logic [TS_WIDTH-1:0]   ts_mem_q  [DEPTH];

    // ------------------------------------------------------------------
    // Detection and FIFO control (combinational)
    // ------------------------------------------------------------------
    logic          fifo_empty;
    logic          fifo_full;
    logic          evt;
    logic          push;
    logic          pop;
    logic          drop;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Full/empty and the push/pop/drop decisions for this cycle.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        evt        = in_valid && (din != prev_q);
        pop        = out_ready && !fifo_empty;
        // A pop in the same cycle frees the head slot, so a full FIFO can
        // still take the new event; the write lands where the head was.
        push       = evt && (!fifo_full || pop);
        drop       = evt && fifo_full && !pop;
    end

    // Next-state for sample tracking, pointers and overflow bookkeeping.
    always_comb begin
        prev_d     = prev_q;
        ts_cnt_d   = ts_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        // Only accepted samples move the previous value and the index;
        // prev follows din even when the resulting event is dropped.
        if (in_valid) begin
            prev_d   = din;
            ts_cnt_d = ts_next(ts_cnt_q);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // A drop outranks a simultaneous clear so the drop is never lost:
        // the clear wipes history and this drop becomes the first one.
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = clear_ovf ? DROP_WIDTH'(1) : sat_inc(drop_cnt_q);
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registered state: control flops with synchronous active-low reset
    // ------------------------------------------------------------------
    // Control state; reset also discards every stored event by zeroing
    // both pointers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_q     <= '0;
            ts_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            prev_q     <= prev_d;
            ts_cnt_q   <= ts_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Event storage write; the event carries the index before increment.
    always_ff @(posedge clk) begin
        if (push) begin
            val_mem_q[wr_idx] <= din;
            ts_mem_q[wr_idx]  <= ts_cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head is read straight from storage (first-word-fall-through)
    // ------------------------------------------------------------------
    // out_valid depends only on registered pointers, so there is no
    // combinational path from out_ready to out_valid.
    always_comb begin
        out_valid  = !fifo_empty;
        out_value  = fifo_empty ? '0 : val_mem_q[rd_idx];
        out_ts     = fifo_empty ? '0 : ts_mem_q[rd_idx];
        count      = wr_ptr_q - rd_ptr_q;
        overflow   = overflow_q;
        drop_count = drop_cnt_q;
    end

endmodule
